// File: rtl/line_rasterizer.sv
// ---------------------------------------------------------------------------
// line_rasterizer
//
// Bresenham line rasterizer. Accepts one segment (x1,y1)->(x2,y2) per start
// pulse while idle and streams every pixel of the segment, endpoints
// inclusive, over a valid/ready handshake towards the framebuffer writer.
// Sequence per segment: IDLE -> SETUP (1 cycle) -> DRAW -> IDLE.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   x1, y1       segment start, sampled when start is accepted
//   x2, y2       segment end, sampled when start is accepted
//   start        begin a segment; honoured only while ready=1
//   ready        idle and able to accept start
//   pixel_x/y    current pixel coordinate
//   pixel_valid  pixel_x/pixel_y hold a pixel to write
//   pixel_ready  downstream accepts the pixel this cycle
//
// Optional feature (compile-time macro LINE_RASTERIZER_CLIP_EN):
//   defined   - pixels outside HOR_ACTIVE_PIXELS x VER_ACTIVE_PIXELS are not
//               presented; the walker steps past them one per cycle.
//   undefined - every pixel of the segment is presented.
// ---------------------------------------------------------------------------
module line_rasterizer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    input  logic               start,
    output logic               ready,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);

    // err carries max(X_WIDTH,Y_WIDTH)+2 signed bits; e2, dx and dy live one
    // bit wider so that 2*err and the comparisons against -dy/dx never wrap.
    localparam int MW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int EW = MW + 2;

    localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);
    localparam logic [EW-X_WIDTH:0] X_PAD = '0;
    localparam logic [EW-Y_WIDTH:0] Y_PAD = '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } state_t;

    state_t state, state_n;

    // Latched segment and walker state
    logic [X_WIDTH-1:0]  x1_r, x2_r, cur_x;
    logic [Y_WIDTH-1:0]  y1_r, y2_r, cur_y;
    logic signed [EW:0]  dx, dy;
    logic                sx_neg, sy_neg;
    logic signed [EW-1:0] err;

    // Combinational helpers
    logic                on_screen;
    logic                advance;
    logic                at_end;
    logic signed [EW:0]  dx_init, dy_init, diff_init;
    logic signed [EW:0]  e2, err_ext, err_sum;
    logic                step_x, step_y;

    assign pixel_x = cur_x;
    assign pixel_y = cur_y;
    assign at_end  = (cur_x == x2_r) && (cur_y == y2_r);

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);
    assign on_screen = ({1'b0, cur_x} < X_LIMIT) && ({1'b0, cur_y} < Y_LIMIT);
`else
    assign on_screen = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n     = state;
        ready       = 1'b0;
        pixel_valid = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_n = SETUP;
            end
            SETUP: begin
                state_n = DRAW;
            end
            DRAW: begin
                pixel_valid = on_screen;
                // Off-screen pixels (clip build only) step without a handshake.
                advance     = on_screen ? pixel_ready : 1'b1;
                if (advance && at_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bresenham arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        dx_init   = (x2_r >= x1_r) ? $signed({X_PAD, x2_r - x1_r})
                                   : $signed({X_PAD, x1_r - x2_r});
        dy_init   = (y2_r >= y1_r) ? $signed({Y_PAD, y2_r - y1_r})
                                   : $signed({Y_PAD, y1_r - y2_r});
        diff_init = dx_init - dy_init;

        e2      = $signed({err, 1'b0});
        err_ext = $signed({err[EW-1], err});
        // Both decisions use the pre-update err.
        step_x  = e2 > -dy;
        step_y  = e2 < dx;
        err_sum = err_ext;
        if (step_x) err_sum = err_sum - dy;
        if (step_y) err_sum = err_sum + dx;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the datapath is reset too: pixel_x/pixel_y must read 0 after
    // reset and the registers are few, so there is no reason to skip it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x1_r   <= '0;
            y1_r   <= '0;
            x2_r   <= '0;
            y2_r   <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x1_r <= x1;
                        y1_r <= y1;
                        x2_r <= x2;
                        y2_r <= y2;
                    end
                end
                SETUP: begin
                    dx     <= dx_init;
                    dy     <= dy_init;
                    sx_neg <= x2_r < x1_r;
                    sy_neg <= y2_r < y1_r;
                    err    <= diff_init[EW-1:0];
                    cur_x  <= x1_r;
                    cur_y  <= y1_r;
                end
                DRAW: begin
                    if (advance && !at_end) begin
                        if (step_x) cur_x <= sx_neg ? cur_x - X_ONE : cur_x + X_ONE;
                        if (step_y) cur_y <= sy_neg ? cur_y - Y_ONE : cur_y + Y_ONE;
                        err <= err_sum[EW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_line_rasterizer
//
// Self-checking bench for line_rasterizer. Expected pixels are pushed to a
// scoreboard queue when a segment is started (fixed lists or a reference
// Bresenham walk) and popped by a monitor at each accepted handshake.
// ---------------------------------------------------------------------------
module tb_line_rasterizer;

    localparam int HOR = 640;
    localparam int VER = 480;
    localparam int XW  = $clog2(HOR);
    localparam int YW  = $clog2(VER);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic          start;
    logic          ready;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_valid;
    logic          pixel_ready;

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   accepted = 0;

    always #5 clk = ~clk;

    line_rasterizer #(
        .HOR_ACTIVE_PIXELS(HOR),
        .VER_ACTIVE_PIXELS(VER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .start      (start),
        .ready      (ready),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic push(input int x, input int y);
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    // Textbook Bresenham walk, all pixels inclusive of both endpoints.
    task automatic push_model(input int ax1, input int ay1, input int ax2, input int ay2);
        int x, y, ddx, ddy, sx, sy, e, e2;
        x   = ax1;
        y   = ay1;
        ddx = (ax2 >= ax1) ? ax2 - ax1 : ax1 - ax2;
        ddy = (ay2 >= ay1) ? ay2 - ay1 : ay1 - ay2;
        sx  = (ax2 >= ax1) ? 1 : -1;
        sy  = (ay2 >= ay1) ? 1 : -1;
        e   = ddx - ddy;
        forever begin
            if (x < HOR && y < VER) push(x, y);
            if (x == ax2 && y == ay2) break;
            e2 = 2 * e;
            if (e2 > -ddy) begin e = e - ddy; x = x + sx; end
            if (e2 < ddx)  begin e = e + ddx; y = y + sy; end
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that samples start.
    task automatic drive_start(input int ax1, input int ay1, input int ax2, input int ay2);
        check("ready_before_start", int'(ready), 1);
        x1    = ax1[XW-1:0];
        y1    = ay1[YW-1:0];
        x2    = ax2[XW-1:0];
        y2    = ay2[YW-1:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for the scoreboard to drain and the block to go idle.
    task automatic wait_done(input string tag, input int bound, input bit bp);
        int n;
        n = 0;
        while (!(ready && exp_q.size() == 0) && n < bound) begin
            @(posedge clk);
            #1;
            if (bp) pixel_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        pixel_ready = 1'b1;
        check({tag, "_done"}, int'(ready && exp_q.size() == 0), 1);
        exp_q.delete();
        // No stray pixels after the segment ends.
        repeat (3) begin
            @(posedge clk);
            #1 check({tag, "_quiet"}, int'(pixel_valid), 0);
        end
    endtask

    // Monitor: pops at each handshake, checks hold-stability under stall.
    initial begin
        bit            stalled;
        logic [XW-1:0] hold_x;
        logic [YW-1:0] hold_y;
        pix_t          e;
        stalled = 1'b0;
        hold_x  = '0;
        hold_y  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", int'(pixel_valid), 1);
                    check("hold_x", int'(pixel_x), int'(hold_x));
                    check("hold_y", int'(pixel_y), int'(hold_y));
                end
                if (pixel_valid && pixel_ready) begin
                    check("sb_expects_pixel", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("pix_x", int'(pixel_x), e.x);
                        check("pix_y", int'(pixel_y), e.y);
                    end
                    accepted++;
                    stalled = 1'b0;
                end else if (pixel_valid) begin
                    stalled = 1'b1;
                    hold_x  = pixel_x;
                    hold_y  = pixel_y;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc0;
        bit hit;

        rst_n       = 1'b0;
        start       = 1'b0;
        pixel_ready = 1'b1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_px", int'(pixel_x), 0);
        check("rst_py", int'(pixel_y), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Horizontal: latency and throughput
        push(0, 240); push(1, 240); push(2, 240); push(3, 240);
        drive_start(0, 240, 3, 240);
        check("horiz_setup_valid", int'(pixel_valid), 0);
        check("horiz_setup_ready", int'(ready), 0);
        @(posedge clk);
        #1;
        check("horiz_first_valid", int'(pixel_valid), 1);
        check("horiz_first_x", int'(pixel_x), 0);
        check("horiz_first_y", int'(pixel_y), 240);
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("horiz_ready_latency", n, 4);
        wait_done("horiz", 20, 1'b0);

        // Steep
        push(5, 5); push(5, 6); push(6, 7); push(6, 8); push(7, 9); push(7, 10);
        drive_start(5, 5, 7, 10);
        wait_done("steep", 50, 1'b0);

        // Reverse octant
        push(7, 3); push(6, 3); push(5, 2); push(4, 2); push(3, 1); push(2, 1);
        drive_start(7, 3, 2, 1);
        wait_done("reverse", 50, 1'b0);

        // Single point with backpressure and a start while busy
        pixel_ready = 1'b0;
        push(10, 10);
        drive_start(10, 10, 10, 10);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("point_valid", int'(pixel_valid), 1);
            check("point_x", int'(pixel_x), 10);
            check("point_y", int'(pixel_y), 10);
            check("point_busy", int'(ready), 0);
            if (i == 1) begin
                x1 = 10'd50; y1 = 9'd50; x2 = 10'd60; y2 = 9'd60;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        acc0 = accepted;
        pixel_ready = 1'b1;
        wait_done("point", 20, 1'b0);
        check("point_accept_count", accepted - acc0, 1);

        // Reset mid-line
        push_model(0, 0, 100, 0);
        acc0 = accepted;
        drive_start(0, 0, 100, 0);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (accepted == acc0 + 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_mid_reached", int'(hit), 1);
        @(posedge clk);
        #1;
        pixel_ready = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", int'(pixel_valid), 0);
        check("rst_mid_ready", int'(ready), 1);
        check("rst_mid_px", int'(pixel_x), 0);
        check("rst_mid_accepted", accepted - acc0, 3);
        exp_q.delete();
        rst_n       = 1'b1;
        pixel_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 check("rst_mid_quiet", int'(pixel_valid), 0);
        end
        push(20, 30); push(21, 30); push(22, 31);
        drive_start(20, 30, 22, 31);
        wait_done("after_rst", 50, 1'b0);

        // Off-screen tail
        push(0, 478); push(1, 479);
`ifndef LINE_RASTERIZER_CLIP_EN
        push(2, 480); push(3, 481);
`endif
        drive_start(0, 478, 3, 481);
        wait_done("clip", 50, 1'b0);

        // Random segments against the reference walk, random backpressure
        for (int k = 0; k < 6; k++) begin
            int ax1, ay1, ax2, ay2;
            ax1 = $urandom_range(0, HOR - 1);
            ay1 = $urandom_range(0, VER - 1);
            ax2 = (k < 3) ? $urandom_range(0, 40) : $urandom_range(0, HOR - 1);
            ay2 = (k < 3) ? $urandom_range(0, 40) : $urandom_range(0, VER - 1);
            push_model(ax1, ay1, ax2, ay2);
            drive_start(ax1, ay1, ax2, ay2);
            wait_done("random", 4000, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
